// File: rtl/odelay_tap_model.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | odelay_tap_model : cycle-approximate output delay line with tap control  |
// | Optional feature macro: ODELAY_SATURATE_EN (tap saturates at 0/31)       |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module odelay_tap_model #(
  parameter string       ODELAY_TYPE         = "FIXED",
  parameter int unsigned ODELAY_VALUE        = 0,
  parameter logic        IS_C_INVERTED       = 1'b0,
  parameter logic        IS_ODATAIN_INVERTED = 1'b0
) (
  input  logic       C,
  input  logic       RST,
  input  logic       CE,
  input  logic       INC,
  input  logic       LD,
  input  logic       LDPIPEEN,
  input  logic [4:0] CNTVALUEIN,
  input  logic       ODATAIN,
  output logic       DATAOUT,
  output logic [4:0] CNTVALUEOUT
);

  localparam logic [2:0] c_mode_fixed = 3'd0;
  localparam logic [2:0] c_mode_var   = 3'd1;
  localparam logic [2:0] c_mode_load  = 3'd2;
  localparam logic [2:0] c_mode_pipe  = 3'd3;
  localparam logic [2:0] c_mode_bad   = 3'd4;

  localparam logic [2:0] c_mode =
    (ODELAY_TYPE == "FIXED")         ? c_mode_fixed :
    (ODELAY_TYPE == "VARIABLE")      ? c_mode_var   :
    (ODELAY_TYPE == "VAR_LOAD")      ? c_mode_load  :
    (ODELAY_TYPE == "VAR_LOAD_PIPE") ? c_mode_pipe  : c_mode_bad;

  localparam logic [4:0] c_init = ODELAY_VALUE[4:0];

  generate
    if (c_mode == c_mode_bad || ODELAY_VALUE > 31) begin : g_cfg_err
      $fatal(1, "ERROR %m");
    end
  endgenerate

  logic w_clk;
  generate
    if (IS_C_INVERTED) begin : g_clk_inv
      assign w_clk = ~C;
    end else begin : g_clk_dir
      assign w_clk = C;
    end
  endgenerate

  logic w_din;
  assign w_din = ODATAIN ^ IS_ODATAIN_INVERTED;

  logic [4:0]  tap_q, tap_d;
  logic [4:0]  pipe_q, pipe_d;
  logic [4:0]  cnt_q;
  logic        dout_q;
  // The deepest tap (31) reads hist_q[30]; a 32nd stage would never be observed.
  logic [30:0] hist_q;

  always_comb begin
    tap_d  = tap_q;
    pipe_d = pipe_q;
    if (c_mode != c_mode_fixed) begin
      if (c_mode == c_mode_pipe && LDPIPEEN) begin
        pipe_d = CNTVALUEIN;
      end
      if (LD) begin
        case (c_mode)
          c_mode_var:  tap_d = c_init;
          c_mode_load: tap_d = CNTVALUEIN;
          default:     tap_d = pipe_q;
        endcase
      end else if (CE) begin
        if (INC) begin
`ifdef ODELAY_SATURATE_EN
          if (tap_q != 5'd31) tap_d = tap_q + 5'd1;
`else
          tap_d = tap_q + 5'd1;
`endif
        end else begin
`ifdef ODELAY_SATURATE_EN
          if (tap_q != 5'd0) tap_d = tap_q - 5'd1;
`else
          tap_d = tap_q - 5'd1;
`endif
        end
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (RST) begin
      tap_q  <= c_init;
      pipe_q <= 5'd0;
      hist_q <= '0;
      dout_q <= 1'b0;
      cnt_q  <= c_init;
    end else begin
      tap_q  <= tap_d;
      pipe_q <= pipe_d;
      hist_q <= {hist_q[29:0], w_din};
      dout_q <= (tap_q == 5'd0) ? w_din : hist_q[tap_q - 5'd1];
      cnt_q  <= tap_q;
    end
  end

  assign DATAOUT     = dout_q;
  assign CNTVALUEOUT = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_odelay_tap_model.sv
`default_nettype none
// Scoreboard bench for odelay_tap_model: five parameterisations share one stimulus bus.
module tb_odelay_tap_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ce, inc, ld, ldp, odata;
  logic [4:0] cin;
  logic       dout [5];
  logic [4:0] cnt  [5];

  int cyc = 0, ncyc = 0, total = 0, bad = 0;
  always @(posedge clk) cyc  <= cyc + 1;
  always @(negedge clk) ncyc <= ncyc + 1;

  odelay_tap_model #(.ODELAY_TYPE("FIXED"), .ODELAY_VALUE(5)) u_fixed (
    .C(clk), .RST(rst), .CE(ce), .INC(inc), .LD(ld), .LDPIPEEN(ldp), .CNTVALUEIN(cin),
    .ODATAIN(odata), .DATAOUT(dout[0]), .CNTVALUEOUT(cnt[0]));
  odelay_tap_model #(.ODELAY_TYPE("VARIABLE"), .ODELAY_VALUE(30)) u_var (
    .C(clk), .RST(rst), .CE(ce), .INC(inc), .LD(ld), .LDPIPEEN(ldp), .CNTVALUEIN(cin),
    .ODATAIN(odata), .DATAOUT(dout[1]), .CNTVALUEOUT(cnt[1]));
  odelay_tap_model #(.ODELAY_TYPE("VAR_LOAD"), .ODELAY_VALUE(3)) u_load (
    .C(clk), .RST(rst), .CE(ce), .INC(inc), .LD(ld), .LDPIPEEN(ldp), .CNTVALUEIN(cin),
    .ODATAIN(odata), .DATAOUT(dout[2]), .CNTVALUEOUT(cnt[2]));
  odelay_tap_model #(.ODELAY_TYPE("VAR_LOAD_PIPE"), .ODELAY_VALUE(0)) u_pipe (
    .C(clk), .RST(rst), .CE(ce), .INC(inc), .LD(ld), .LDPIPEEN(ldp), .CNTVALUEIN(cin),
    .ODATAIN(odata), .DATAOUT(dout[3]), .CNTVALUEOUT(cnt[3]));
  odelay_tap_model #(.ODELAY_TYPE("VARIABLE"), .ODELAY_VALUE(2),
                     .IS_C_INVERTED(1'b1), .IS_ODATAIN_INVERTED(1'b1)) u_inv (
    .C(clk), .RST(rst), .CE(ce), .INC(inc), .LD(ld), .LDPIPEEN(ldp), .CNTVALUEIN(cin),
    .ODATAIN(odata), .DATAOUT(dout[4]), .CNTVALUEOUT(cnt[4]));

  typedef struct {
    int         unit;
    int         at;
    bit         chkd;
    logic       d;
    bit         chkc;
    logic [4:0] c;
    string      name;
  } exp_t;

  exp_t q_pos[$];
  exp_t q_neg[$];

`ifdef ODELAY_SATURATE_EN
  localparam bit c_sat = 1'b1;
`else
  localparam bit c_sat = 1'b0;
`endif

  // Unit 4 runs on falling edges, so its expectations are indexed by falling-edge count.
  task automatic expect_out(input int unit, input int off, input bit chkd, input logic d,
                            input bit chkc, input logic [4:0] c, input string name);
    exp_t e;
    e.unit = unit; e.chkd = chkd; e.d = d; e.chkc = chkc; e.c = c; e.name = name;
    if (unit == 4) begin
      e.at = ncyc + off;
      q_neg.push_back(e);
    end else begin
      e.at = cyc + off;
      q_pos.push_back(e);
    end
  endtask

  task automatic check_entry(input exp_t e);
    if (e.chkd) begin
      total++;
      if (dout[e.unit] !== e.d) begin
        bad++;
        $display("FAIL %s DATAOUT got=%b want=%b", e.name, dout[e.unit], e.d);
      end
    end
    if (e.chkc) begin
      total++;
      if (cnt[e.unit] !== e.c) begin
        bad++;
        $display("FAIL %s CNTVALUEOUT got=%0d want=%0d", e.name, cnt[e.unit], e.c);
      end
    end
  endtask

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < q_pos.size()) begin
      if (q_pos[i].at == cyc) begin
        check_entry(q_pos[i]);
        q_pos.delete(i);
      end else begin
        i++;
      end
    end
  end

  always @(posedge clk) begin
    int i;
    i = 0;
    while (i < q_neg.size()) begin
      if (q_neg[i].at == ncyc) begin
        check_entry(q_neg[i]);
        q_neg.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ce = 1'b0; inc = 1'b0; ld = 1'b0; ldp = 1'b0; odata = 1'b0; cin = 5'd0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; inc = 1'b0; ld = 1'b0; ldp = 1'b0; odata = 1'b0; cin = 5'd0;
    step(2);
    expect_out(0, 0, 1, 1'b0, 1, 5'd5,  "rst_fixed");
    expect_out(1, 0, 1, 1'b0, 1, 5'd30, "rst_var");
    expect_out(2, 0, 1, 1'b0, 1, 5'd3,  "rst_load");
    expect_out(3, 0, 1, 1'b0, 1, 5'd0,  "rst_pipe");
    rst = 1'b0;
    step();

    // T1: fixed tap 5, controls toggled with no effect
    odata = 1'b1; ce = 1'b1; ld = 1'b1; inc = 1'b1; cin = 5'd17;
    expect_out(0, 3, 0, 1'b0, 1, 5'd5, "t1_cnt_hold");
    expect_out(0, 5, 1, 1'b0, 1, 5'd5, "t1_pre");
    expect_out(0, 6, 1, 1'b1, 1, 5'd5, "t1_hit");
    expect_out(0, 7, 1, 1'b0, 1, 5'd5, "t1_post");
    step();
    odata = 1'b0;
    step(3);
    ce = 1'b0; ld = 1'b0; inc = 1'b0;
    step(5);

    // T2: increment across the wrap/saturation point, then decrement
    do_reset();
    ce = 1'b1; inc = 1'b1;
    expect_out(1, 1, 0, 1'b0, 1, 5'd30, "t2_start");
    expect_out(1, 2, 0, 1'b0, 1, 5'd31, "t2_inc1");
    expect_out(1, 3, 0, 1'b0, 1, c_sat ? 5'd31 : 5'd0, "t2_inc2");
    expect_out(1, 4, 0, 1'b0, 1, c_sat ? 5'd31 : 5'd1, "t2_inc3");
    expect_out(1, 5, 0, 1'b0, 1, c_sat ? 5'd30 : 5'd0, "t2_dec");
    step(3);
    inc = 1'b0;
    step();
    ce = 1'b0;
    step(3);

    // T3: LD beats CE, then latency 13 through tap 12
    do_reset();
    cin = 5'd12; ld = 1'b1; ce = 1'b1; inc = 1'b1;
    expect_out(2, 1, 0, 1'b0, 1, 5'd3,  "t3_cnt_old");
    expect_out(2, 2, 0, 1'b0, 1, 5'd12, "t3_ld_wins");
    step();
    ld = 1'b0; ce = 1'b0; inc = 1'b0; odata = 1'b1;
    expect_out(2, 12, 1, 1'b0, 0, 5'd0,  "t3_pre");
    expect_out(2, 13, 1, 1'b1, 1, 5'd12, "t3_lat13");
    expect_out(2, 14, 1, 1'b0, 0, 5'd0,  "t3_post");
    step();
    odata = 1'b0;
    step(14);

    // T4: pipelined load takes the old pipe value when LD and LDPIPEEN coincide
    do_reset();
    ldp = 1'b1; cin = 5'd7;
    expect_out(3, 2, 0, 1'b0, 1, 5'd0, "t4_no_ld");
    expect_out(3, 3, 0, 1'b0, 1, 5'd7, "t4_old_pipe");
    expect_out(3, 4, 0, 1'b0, 1, 5'd9, "t4_new_pipe");
    step();
    ld = 1'b1; cin = 5'd9;
    step();
    ldp = 1'b0;
    step();
    ld = 1'b0;
    step(3);

    // T5: reset mid-stream at tap 20 clears history, ignores INC
    do_reset();
    cin = 5'd20; ld = 1'b1;
    step();
    ld = 1'b0;
    for (int k = 0; k < 20; k++) begin
      odata = 1'($urandom_range(0, 1));
      step();
    end
    odata = 1'b1;
    step(25);
    expect_out(2, 0, 1, 1'b1, 1, 5'd20, "t5_before_rst");
    rst = 1'b1; ce = 1'b1; inc = 1'b1;
    for (int k = 1; k <= 4; k++) expect_out(2, k, 1, 1'b0, 1, 5'd3, "t5_flushed");
    expect_out(2, 5, 1, 1'b1, 1, 5'd3, "t5_refill");
    step();
    rst = 1'b0; ce = 1'b0; inc = 1'b0;
    step(6);

    // T6: falling-edge clock and inverted data
    do_reset();
    expect_out(4, 1, 0, 1'b0, 1, 5'd2, "t6_rst_cnt");
    expect_out(4, 2, 1, 1'b0, 0, 5'd0, "t6_pre");
    expect_out(4, 3, 1, 1'b1, 0, 5'd0, "t6_inv_lat");
    step(5);
    odata = 1'b1;
    expect_out(4, 2, 1, 1'b1, 0, 5'd0, "t6_pulse_pre");
    expect_out(4, 3, 1, 1'b0, 0, 5'd0, "t6_pulse");
    expect_out(4, 4, 1, 1'b1, 0, 5'd0, "t6_pulse_post");
    step();
    odata = 1'b0;
    step(4);
    ce = 1'b1; inc = 1'b1;
    expect_out(4, 1, 0, 1'b0, 1, 5'd2, "t6_inc_pending");
    expect_out(4, 2, 0, 1'b0, 1, 5'd3, "t6_one_inc");
    step();
    ce = 1'b0; inc = 1'b0;
    step(4);

    step(3);
    foreach (q_pos[i]) begin
      total++; bad++;
      $display("FAIL %s never checked got=pending want=checked", q_pos[i].name);
    end
    foreach (q_neg[i]) begin
      total++; bad++;
      $display("FAIL %s never checked got=pending want=checked", q_neg[i].name);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
